// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
// No logic of its own; imported by the interface and the top.
// Counter width helper keeps a 1-bit minimum so WIDTH=2 still gets a real register.
package serial_adder_pkg;

  // Default operand width for the lab build
  localparam int DEF_WIDTH = 8;

  // Controller states; encodings are fixed so debug probes can decode them
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..width-1 bit positions
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between the stimulus logic (master) and the serial adder (slave).
// Pure wiring, no latency.
// No backpressure: start is a request that is ignored while the adder is busy.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used as the datapath of the serial adder.
// Purely combinational, zero latency.
// No flow control.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_cout
);

  logic w_axb;

  assign w_axb  = i_a ^ i_b;
  assign o_sum  = w_axb ^ i_c;
  assign o_cout = (i_a & i_b) | (i_c & w_axb);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, registered carry.
// Latency: start accepted at edge k, busy for WIDTH cycles, done pulses in the cycle after.
// start is only accepted in IDLE or DONE; requests while busy are dropped, not queued.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           i_clk,
  input  logic           i_rst,
  serial_adder_if.slave  io_bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_nxt;

  // The one adder cell always looks at the current LSBs and the carry flop
  full_adder u_fa (
    .i_a    (r_opa[0]),
    .i_b    (r_opb[0]),
    .i_c    (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
  assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};

  // State register; reset aborts any addition in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // start is deliberately not looked at here
        w_shift = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A request in the done cycle reloads directly without an idle bubble
        if (io_bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand, carry, counter and partial-result shift registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_opa   <= io_bus.a;
      r_opb   <= io_bus.b;
      r_res   <= '0;
      r_carry <= io_bus.cin;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_res   <= w_res_nxt;
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Result registers change only when the last bit is produced, so sum/cout
  // keep showing the previous answer for the whole of the next addition
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_res_nxt;
      r_cout <= w_c;
    end
  end

  // busy and done are state decodes, so they can never overlap
  assign io_bus.busy = (r_state == S_SHIFT);
  assign io_bus.done = (r_state == S_DONE);
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random operands
// compared against a plain-arithmetic model of {cout,sum} = a + b + cin.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W:0] last;
  logic [W:0] exp1;
  logic [W:0] exp2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the full (W+1)-bit arithmetic sum
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Present a request so it is sampled on the next rising edge, then drop it
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Called just after the accepting edge; returns at the falling edge of the done cycle
  task automatic wait_done(input string tag, input logic [W:0] exp, input logic [W:0] hold);
    int lat;
    bit seen;
    bit busy_ok;
    bit hold_ok;
    lat     = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if ({bus.cout, bus.sum} !== hold) hold_ok = 1'b0;
      lat++;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(W));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_nobusy"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum"}, 32'({bus.cout, bus.sum}), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] da [4];
    logic [W-1:0] db [4];
    logic         dc [4];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           lat;
    bit           seen;
    bit           no_done;

    da = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    db = '{8'h00, 8'h01, 8'h5A, 8'h42};
    dc = '{1'b0, 1'b0, 1'b1, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst  = 1'b0;
    last = '0;

    // Directed operands, including a full carry ripple
    for (int i = 0; i < 4; i++) begin
      exp1 = ref_add(da[i], db[i], dc[i]);
      issue(da[i], db[i], dc[i]);
      wait_done($sformatf("dir%0d", i), exp1, last);
      last = exp1;
      @(negedge clk);
      check($sformatf("dir%0d_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("dir%0d_idle", i), 32'(bus.busy), 32'd0);
    end

    // A start pulse in the third shift cycle must be dropped
    exp1 = ref_add(8'h12, 8'h34, 1'b0);
    issue(8'h12, 8'h34, 1'b0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      lat++;
      if (lat == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("ign_seen", 32'(seen), 32'd1);
    check("ign_lat", 32'(lat), 32'(W));
    check("ign_sum", 32'({bus.cout, bus.sum}), 32'(exp1));
    @(negedge clk);
    check("ign_noqueue", 32'(bus.busy), 32'd0);
    last = exp1;

    // Reset during the fourth shift cycle aborts with no done pulse
    issue(8'h55, 8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    no_done = 1'b1;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
    end
    check("abort_quiet", 32'(no_done), 32'd1);
    last = '0;

    // Reset and start on the same edge: reset wins
    rst       = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rststart_busy", 32'(bus.busy), 32'd0);
    check("rststart_done", 32'(bus.done), 32'd0);

    // Start held in the done cycle reloads immediately; first result stays visible
    exp1 = ref_add(8'h21, 8'h0F, 1'b0);
    issue(8'h21, 8'h0F, 1'b0);
    wait_done("b2b1", exp1, last);
    exp2 = ref_add(8'h80, 8'h80, 1'b0);
    issue(8'h80, 8'h80, 1'b0);
    wait_done("b2b2", exp2, exp1);
    last = exp2;
    @(negedge clk);

    // Random operands, sometimes back to back, sometimes with idle gaps
    for (int n = 0; n < 25; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      exp1 = ref_add(ra, rb, rc);
      issue(ra, rb, rc);
      wait_done($sformatf("rnd%0d", n), exp1, last);
      last = exp1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
